cpu_mem_arbiter: RTL and testbench
==================================

Name: cpu_mem_arbiter

Overview:
- Shares the single read/write port (port A) of the CHIP-8 main memory between three requesters:
  - ROM loader (write-only)
  - CPU (fetch/exec, read/write)
  - draw engine (sprite reads, read-only)
- Fixed priority loader > CPU > draw, with a starvation counter and an atomic lock for multi-byte sequences (opcode fetch, sprite rows).
- Drives the memory's en/write/addr/wdata and returns read data with a per-requester valid strobe.
- Port B (video scan-out) is not touched.

Parameters:
- ADDR_W, 12, memory address width (4 KiB CHIP-8 space).
- DATA_W, 8, data byte width.
- STARVE_LIMIT, 4, consecutive lost cycles after which the draw engine outranks the CPU; 1..15.

Ports:
- clk  in  1  single system clock; memory port A shares it.
- reset  in  1  asynchronous, active-high reset.
- ld_req  in  1  loader write request.
- ld_addr  in  ADDR_W  loader address.
- ld_wdata  in  DATA_W  loader write byte.
- ld_gnt  out  1  loader access accepted this cycle.
- cpu_req  in  1  CPU request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_lock  in  1  hold ownership after this grant.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write byte.
- cpu_gnt  out  1  CPU access accepted this cycle.
- cpu_rvalid  out  1  rdata belongs to a CPU read.
- drw_req  in  1  draw engine read request.
- drw_lock  in  1  hold ownership after this grant.
- drw_addr  in  ADDR_W  draw engine address.
- drw_gnt  out  1  draw access accepted this cycle.
- drw_rvalid  out  1  rdata belongs to a draw read.
- rdata  out  DATA_W  read data, shared, qualified by *_rvalid.
- mem_en  out  1  memory port enable.
- mem_write  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; 1-cycle synchronous read, no output register.

Behaviour:
- Handshake
  - A requester holds req/addr/wdata/we stable until it sees its gnt.
  - gnt is combinational from the registered state and the current reqs; at most one gnt is high per cycle.
  - Fields may change in the cycle after gnt.
- Pipeline
  - Cycle T: gnt=1.
  - Cycle T+1: registered mem_en=1, mem_write=we, mem_addr/mem_wdata = the values granted at T.
  - Cycle T+2: for reads, the owner's rvalid=1 and rdata = mem_rdata, both registered.
  - Writes produce no rvalid. Throughput is one access per cycle; back-to-back grants are legal.
  - Two-stage tag pipe: {valid, is_read, owner} travels with each access.
- FSM states: IDLE, LOCK_CPU, LOCK_DRW.
  - IDLE, grant priority:
    - ld_req first.
    - else drw_req, if drw_wait == STARVE_LIMIT.
    - else cpu_req.
    - else drw_req.
  - A CPU grant with cpu_lock=1 -> LOCK_CPU. A draw grant with drw_lock=1 -> LOCK_DRW.
  - LOCK_x: only requester x can be granted, including the loader being blocked.
  - LOCK_x -> IDLE in any cycle where x_lock=0; a grant to x in that same cycle is still allowed, as the final access.
  - An owner dropping req while keeping lock keeps ownership; other requesters wait.
- Starvation counter drw_wait, 4 bits:
  - +1 each cycle drw_req=1 and drw_gnt=0, saturating at STARVE_LIMIT.
  - Cleared on drw_gnt or when drw_req=0.
- Idle memory outputs: with no grant, the next cycle has mem_en=0 and mem_write=0; mem_addr/mem_wdata hold their last value.
- Reset values (async, immediate): state=IDLE, drw_wait=0, tag pipe cleared, mem_en=0, mem_write=0, mem_addr=0, mem_wdata=0, rdata=0, all rvalid=0. All gnt=0 while reset is high.
- Reset mid-operation: in-flight reads are discarded with no rvalid, and locks are released.
- Loader during CPU operation is legal. It only waits for an active lock and then preempts the CPU; the system holds the CPU in reset while loading.

Decomposition:
- Shared package (chip8_pkg):
  - owner encoding constants: OWN_NONE=0, OWN_LD=1, OWN_CPU=2, OWN_DRW=3;
  - arbiter state constants;
  - ADDR_W/DATA_W defaults.
- One natural sub-module: mem_arb_priority, the combinational grant select (state, reqs, starve flag -> one-hot gnt). FSM, counter and tag pipe stay in the top.

Test Plan:
- CPU read 0x200 with memory containing 0x00E0 at 0x200 -> cpu_gnt at T; mem_en=1, mem_addr=0x200 at T+1; cpu_rvalid=1, rdata=0x00 at T+2.
- ld_req and cpu_req asserted together in IDLE -> ld_gnt first. Loader write 0xA2 to 0x300 lands in memory (mem_write=1 at T+1). CPU is granted the next cycle, and a read of 0x300 returns 0xA2.
- CPU holds cpu_lock for a 2-byte fetch 0x200/0x201 while drw_req and ld_req are both high -> two consecutive cpu_gnt. No other gnt until cpu_lock falls.
- cpu_req held continuously, drw_req high, STARVE_LIMIT=4 -> drw_gnt on the 5th cycle of waiting; drw_wait returns to 0.
- Draw locked burst of 5 sprite bytes 0x050..0x054 -> five drw_rvalid pulses with bytes F0,90,90,90,F0 in order; drw_rvalid never coincides with cpu_rvalid.
- Assert reset with a CPU read issued one cycle earlier -> no cpu_rvalid, mem_en=0 immediately. After release, the FSM is IDLE and the first request is granted normally.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared CHIP-8 definitions for the main-memory port A arbiter.
//   - default address/data widths of the 4 KiB CHIP-8 memory
//   - owner encoding carried with each memory access
//   - arbiter FSM states and the access tag structure
package chip8_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DATA_W_DEF = 8;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_LD   = 2'd1;
    localparam logic [1:0] OWN_CPU  = 2'd2;
    localparam logic [1:0] OWN_DRW  = 2'd3;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLockCpu = 2'd1,
        StLockDrw = 2'd2
    } arb_state_e;

    // Travels alongside each access through the two-stage pipe.
    typedef struct packed {
        logic       valid;
        logic       is_read;
        logic [1:0] owner;
    } mem_tag_t;

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// Bundle of requester handshakes and memory port A signals for cpu_mem_arbiter.
//   slave  : arbiter side (takes reqs and mem_rdata, drives gnts, rvalids, rdata, mem_*)
//   master : requester/memory side (the mirror image)
interface cpu_mem_arbiter_if #(
    parameter int unsigned ADDR_W = chip8_pkg::ADDR_W_DEF,
    parameter int unsigned DATA_W = chip8_pkg::DATA_W_DEF
);
    // Loader (write-only)
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;
    // CPU (read/write)
    logic              cpu_req;
    logic              cpu_we;
    logic              cpu_lock;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    // Draw engine (read-only)
    logic              drw_req;
    logic              drw_lock;
    logic [ADDR_W-1:0] drw_addr;
    logic              drw_gnt;
    logic              drw_rvalid;
    // Shared read return
    logic [DATA_W-1:0] rdata;
    // Memory port A
    logic              mem_en;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  ld_req, ld_addr, ld_wdata,
        input  cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
        input  drw_req, drw_lock, drw_addr,
        input  mem_rdata,
        output ld_gnt, cpu_gnt, cpu_rvalid, drw_gnt, drw_rvalid, rdata,
        output mem_en, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output ld_req, ld_addr, ld_wdata,
        output cpu_req, cpu_we, cpu_lock, cpu_addr, cpu_wdata,
        output drw_req, drw_lock, drw_addr,
        output mem_rdata,
        input  ld_gnt, cpu_gnt, cpu_rvalid, drw_gnt, drw_rvalid, rdata,
        input  mem_en, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_priority.sv
// Combinational grant select for cpu_mem_arbiter.
//   state   : current arbiter FSM state
//   *_req   : requests from loader, CPU, draw engine
//   starve  : draw engine has waited the starvation limit
//   *_gnt   : one-hot grant (at most one high)
module mem_arb_priority (
    input  chip8_pkg::arb_state_e state,
    input  logic                  ld_req,
    input  logic                  cpu_req,
    input  logic                  drw_req,
    input  logic                  starve,
    output logic                  ld_gnt,
    output logic                  cpu_gnt,
    output logic                  drw_gnt
);
    import chip8_pkg::*;

    always_comb begin
        ld_gnt  = 1'b0;
        cpu_gnt = 1'b0;
        drw_gnt = 1'b0;
        unique case (state)
            StIdle: begin
                if (ld_req) begin
                    ld_gnt = 1'b1;
                end else if (drw_req && starve) begin
                    drw_gnt = 1'b1;
                end else if (cpu_req) begin
                    cpu_gnt = 1'b1;
                end else if (drw_req) begin
                    drw_gnt = 1'b1;
                end
            end
            // A lock excludes everyone else, the loader included.
            StLockCpu: cpu_gnt = cpu_req;
            StLockDrw: drw_gnt = drw_req;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates CHIP-8 main memory port A between the ROM loader, the CPU and the draw engine.
//   clk   : system clock, shared with memory port A
//   reset : asynchronous active-high reset
//   bus   : requester handshakes (req/gnt/rvalid), shared rdata and memory port A drive
// Grant at T, registered memory command at T+1, read data with owner rvalid at T+2.
module cpu_mem_arbiter #(
    parameter int unsigned ADDR_W       = chip8_pkg::ADDR_W_DEF,
    parameter int unsigned DATA_W       = chip8_pkg::DATA_W_DEF,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic              clk,
    input logic              reset,
    cpu_mem_arbiter_if.slave bus
);
    import chip8_pkg::*;

    arb_state_e        state_q, state_d;
    logic [3:0]        drw_wait_q, drw_wait_d;
    mem_tag_t          tag_d, tag1_q, tag2_q;
    logic              mem_en_q, mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q;
    logic              starve, read_done;
    logic              ld_sel, cpu_sel, drw_sel;
    logic              ld_gnt, cpu_gnt, drw_gnt;

    assign starve = (drw_wait_q == 4'(STARVE_LIMIT));

    mem_arb_priority u_priority (
        .state   (state_q),
        .ld_req  (bus.ld_req),
        .cpu_req (bus.cpu_req),
        .drw_req (bus.drw_req),
        .starve  (starve),
        .ld_gnt  (ld_sel),
        .cpu_gnt (cpu_sel),
        .drw_gnt (drw_sel)
    );

    // Grants are combinational, so they must be forced low while reset is asserted.
    assign ld_gnt  = ld_sel  & ~reset;
    assign cpu_gnt = cpu_sel & ~reset;
    assign drw_gnt = drw_sel & ~reset;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_gnt && bus.cpu_lock) begin
                    state_d = StLockCpu;
                end else if (drw_gnt && bus.drw_lock) begin
                    state_d = StLockDrw;
                end
            end
            StLockCpu: if (!bus.cpu_lock) state_d = StIdle;
            StLockDrw: if (!bus.drw_lock) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Saturating wait counter; equality with the limit is the starve flag.
    always_comb begin
        drw_wait_d = drw_wait_q;
        if (!bus.drw_req || drw_gnt) begin
            drw_wait_d = '0;
        end else if (!starve) begin
            drw_wait_d = drw_wait_q + 4'd1;
        end
    end

    // Capture the granted access; address/data hold when nothing is granted.
    always_comb begin
        tag_d       = '{valid: 1'b0, is_read: 1'b0, owner: OWN_NONE};
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (ld_gnt) begin
            tag_d       = '{valid: 1'b1, is_read: 1'b0, owner: OWN_LD};
            mem_write_d = 1'b1;
            mem_addr_d  = bus.ld_addr;
            mem_wdata_d = bus.ld_wdata;
        end else if (cpu_gnt) begin
            tag_d       = '{valid: 1'b1, is_read: ~bus.cpu_we, owner: OWN_CPU};
            mem_write_d = bus.cpu_we;
            mem_addr_d  = bus.cpu_addr;
            mem_wdata_d = bus.cpu_wdata;
        end else if (drw_gnt) begin
            tag_d       = '{valid: 1'b1, is_read: 1'b1, owner: OWN_DRW};
            mem_addr_d  = bus.drw_addr;
        end
    end

    assign read_done = tag2_q.valid & tag2_q.is_read;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            drw_wait_q  <= '0;
            tag1_q      <= '0;
            tag2_q      <= '0;
            mem_en_q    <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            drw_wait_q  <= drw_wait_d;
            tag1_q      <= tag_d;
            tag2_q      <= tag1_q;
            mem_en_q    <= tag_d.valid;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if (read_done) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.ld_gnt     = ld_gnt;
    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.drw_gnt    = drw_gnt;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.cpu_rvalid = read_done & (tag2_q.owner == OWN_CPU);
    assign bus.drw_rvalid = read_done & (tag2_q.owner == OWN_DRW);
    // The memory's read register supplies the byte in the rvalid cycle; rdata_q keeps it
    // stable afterwards and gives rdata a defined reset value.
    assign bus.rdata      = read_done ? bus.mem_rdata : rdata_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
module tb_cpu_mem_arbiter;
    import chip8_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    cpu_mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus ();

    cpu_mem_arbiter #(.ADDR_W(12), .DATA_W(8), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Port A memory model: synchronous 1-cycle read, contents preloaded on first clock.
    logic [7:0] mem [0:4095];
    logic [7:0] mem_rd;
    logic       mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
            mem[12'h200] <= 8'h00;
            mem[12'h201] <= 8'hE0;
            mem[12'h050] <= 8'hF0;
            mem[12'h051] <= 8'h90;
            mem[12'h052] <= 8'h90;
            mem[12'h053] <= 8'h90;
            mem[12'h054] <= 8'hF0;
            mem_ready    <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
            else               mem_rd <= mem[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = mem_rd;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.ld_req = 1'b0;    bus.ld_addr = '0;   bus.ld_wdata = '0;
        bus.cpu_req = 1'b0;   bus.cpu_we = 1'b0;  bus.cpu_lock = 1'b0;
        bus.cpu_addr = '0;    bus.cpu_wdata = '0;
        bus.drw_req = 1'b0;   bus.drw_lock = 1'b0; bus.drw_addr = '0;
    endtask

    task automatic test_reset();
        bus.ld_req = 1'b1; bus.cpu_req = 1'b1; bus.drw_req = 1'b1;
        #1;
        n_checks++; if ({bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt} !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b want 000", {bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt}); end
        n_checks++; if ({bus.mem_en, bus.mem_write} !== 2'b00) begin n_fail++; $display("FAIL reset_mem_ctl: got %b want 00", {bus.mem_en, bus.mem_write}); end
        n_checks++; if (bus.mem_addr !== 12'h000) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 000", bus.mem_addr); end
        n_checks++; if (bus.mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 00", bus.mem_wdata); end
        n_checks++; if ({bus.cpu_rvalid, bus.drw_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b want 00", {bus.cpu_rvalid, bus.drw_rvalid}); end
        n_checks++; if (bus.rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", bus.rdata); end
        tick();
        tick();
        drive_idle();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cpu_read();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h200;
        #1;
        n_checks++; if ({bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt} !== 3'b010) begin n_fail++; $display("FAIL cpu_read_gnt: got %b want 010", {bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt}); end
        tick();
        bus.cpu_req = 1'b0;
        n_checks++; if ({bus.mem_en, bus.mem_write} !== 2'b10) begin n_fail++; $display("FAIL cpu_read_cmd: got %b want 10", {bus.mem_en, bus.mem_write}); end
        n_checks++; if (bus.mem_addr !== 12'h200) begin n_fail++; $display("FAIL cpu_read_addr: got %h want 200", bus.mem_addr); end
        tick();
        n_checks++; if ({bus.cpu_rvalid, bus.drw_rvalid} !== 2'b10) begin n_fail++; $display("FAIL cpu_read_rvalid: got %b want 10", {bus.cpu_rvalid, bus.drw_rvalid}); end
        n_checks++; if (bus.rdata !== 8'h00) begin n_fail++; $display("FAIL cpu_read_rdata: got %h want 00", bus.rdata); end
        n_checks++; if ({bus.mem_en, bus.mem_write} !== 2'b00) begin n_fail++; $display("FAIL idle_mem_ctl: got %b want 00", {bus.mem_en, bus.mem_write}); end
        n_checks++; if (bus.mem_addr !== 12'h200) begin n_fail++; $display("FAIL idle_addr_hold: got %h want 200", bus.mem_addr); end
        tick();
        n_checks++; if (bus.cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL cpu_read_single_pulse: got %b want 0", bus.cpu_rvalid); end
    endtask

    task automatic test_ld_priority();
        bus.ld_req = 1'b1; bus.ld_addr = 12'h300; bus.ld_wdata = 8'hA2;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h300;
        #1;
        n_checks++; if ({bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt} !== 3'b100) begin n_fail++; $display("FAIL ld_prio_gnt: got %b want 100", {bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt}); end
        tick();
        bus.ld_req = 1'b0;
        #1;
        n_checks++; if ({bus.mem_en, bus.mem_write} !== 2'b11) begin n_fail++; $display("FAIL ld_write_cmd: got %b want 11", {bus.mem_en, bus.mem_write}); end
        n_checks++; if ({bus.mem_addr, bus.mem_wdata} !== {12'h300, 8'hA2}) begin n_fail++; $display("FAIL ld_write_bus: got %h/%h want 300/a2", bus.mem_addr, bus.mem_wdata); end
        n_checks++; if ({bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt} !== 3'b010) begin n_fail++; $display("FAIL ld_then_cpu_gnt: got %b want 010", {bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt}); end
        tick();
        bus.cpu_req = 1'b0;
        n_checks++; if ({bus.mem_en, bus.mem_write} !== 2'b10) begin n_fail++; $display("FAIL ld_readback_cmd: got %b want 10", {bus.mem_en, bus.mem_write}); end
        tick();
        n_checks++; if (bus.cpu_rvalid !== 1'b1) begin n_fail++; $display("FAIL ld_readback_rvalid: got %b want 1", bus.cpu_rvalid); end
        n_checks++; if (bus.rdata !== 8'hA2) begin n_fail++; $display("FAIL ld_readback_rdata: got %h want a2", bus.rdata); end
        tick();
    endtask

    task automatic test_cpu_lock();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_lock = 1'b1; bus.cpu_addr = 12'h200;
        bus.drw_req = 1'b1; bus.drw_addr = 12'h050;
        #1;
        n_checks++; if ({bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt} !== 3'b010) begin n_fail++; $display("FAIL lock_gnt0: got %b want 010", {bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt}); end
        tick();
        bus.cpu_addr = 12'h201;
        bus.ld_req = 1'b1; bus.ld_addr = 12'h310; bus.ld_wdata = 8'h55;
        #1;
        n_checks++; if ({bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt} !== 3'b010) begin n_fail++; $display("FAIL lock_gnt1: got %b want 010", {bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt}); end
        tick();
        bus.cpu_req = 1'b0;  // owner pauses but keeps the lock
        #1;
        n_checks++; if ({bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt} !== 3'b000) begin n_fail++; $display("FAIL lock_hold_nogrant: got %b want 000", {bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt}); end
        n_checks++; if ({bus.cpu_rvalid, bus.rdata} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL lock_byte0: got %b/%h want 1/00", bus.cpu_rvalid, bus.rdata); end
        tick();
        bus.cpu_lock = 1'b0;
        #1;
        n_checks++; if ({bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt} !== 3'b000) begin n_fail++; $display("FAIL lock_release_cycle: got %b want 000", {bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt}); end
        n_checks++; if ({bus.cpu_rvalid, bus.rdata} !== {1'b1, 8'hE0}) begin n_fail++; $display("FAIL lock_byte1: got %b/%h want 1/e0", bus.cpu_rvalid, bus.rdata); end
        tick();
        #1;
        n_checks++; if ({bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt} !== 3'b100) begin n_fail++; $display("FAIL unlock_ld_first: got %b want 100", {bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt}); end
        tick();
        bus.ld_req = 1'b0;
        #1;
        n_checks++; if ({bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt} !== 3'b001) begin n_fail++; $display("FAIL unlock_drw_next: got %b want 001", {bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt}); end
        tick();
        drive_idle();
        tick(); tick(); tick();
    endtask

    task automatic test_starvation();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h200;
        bus.drw_req = 1'b1; bus.drw_addr = 12'h050;
        for (int i = 0; i < 5; i++) begin
            logic [2:0] exp_g;
            exp_g = (i == 4) ? 3'b001 : 3'b010;
            #1;
            n_checks++; if ({bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt} !== exp_g) begin n_fail++; $display("FAIL starve_gnt[%0d]: got %b want %b", i, {bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt}, exp_g); end
            if (i == 4) begin
                n_checks++; if (dut.drw_wait_q !== 4'd4) begin n_fail++; $display("FAIL starve_wait_sat: got %0d want 4", dut.drw_wait_q); end
            end
            tick();
        end
        bus.drw_addr = 12'h051;
        #1;
        n_checks++; if (dut.drw_wait_q !== 4'd0) begin n_fail++; $display("FAIL starve_wait_clear: got %0d want 0", dut.drw_wait_q); end
        n_checks++; if ({bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt} !== 3'b010) begin n_fail++; $display("FAIL starve_after_gnt: got %b want 010", {bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt}); end
        tick();
        drive_idle();
        tick(); tick(); tick();
    endtask

    task automatic test_draw_burst();
        logic [11:0] addr_t [10] = '{12'h050, 12'h051, 12'h052, 12'h000, 12'h053, 12'h054,
                                     12'h000, 12'h000, 12'h000, 12'h000};
        bit          req_t  [10] = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 0};
        bit          lock_t [10] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        bit          exp_d  [10] = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 0};
        bit          exp_c  [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        logic [7:0]  exp_b  [5]  = '{8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0};
        logic [7:0]  got [$];
        int          cpu_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            n_checks++; if (bus.cpu_rvalid && bus.drw_rvalid) begin n_fail++; $display("FAIL burst_rvalid_overlap[%0d]: got 11 want not both", k); end
            if (bus.drw_rvalid) got.push_back(bus.rdata);
            if (bus.cpu_rvalid) cpu_cnt++;
            bus.drw_req  = req_t[k];
            bus.drw_lock = lock_t[k];
            bus.drw_addr = addr_t[k];
            bus.cpu_req  = (k >= 1 && k <= 6);
            bus.cpu_addr = 12'h200;
            #1;
            n_checks++; if ({bus.cpu_gnt, bus.drw_gnt} !== {exp_c[k], exp_d[k]}) begin n_fail++; $display("FAIL burst_gnt[%0d]: got cpu/drw %b%b want %b%b", k, bus.cpu_gnt, bus.drw_gnt, exp_c[k], exp_d[k]); end
            n_checks++; if (bus.ld_gnt !== 1'b0) begin n_fail++; $display("FAIL burst_ld_gnt[%0d]: got %b want 0", k, bus.ld_gnt); end
            tick();
        end
        drive_idle();
        n_checks++; if (got.size() != 5) begin n_fail++; $display("FAIL burst_count: got %0d want 5", got.size()); end
        for (int j = 0; j < 5; j++) begin
            if (j < got.size()) begin
                n_checks++; if (got[j] !== exp_b[j]) begin n_fail++; $display("FAIL burst_byte[%0d]: got %h want %h", j, got[j], exp_b[j]); end
            end
        end
        n_checks++; if (cpu_cnt != 1) begin n_fail++; $display("FAIL burst_cpu_rvalid_count: got %0d want 1", cpu_cnt); end
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_lock = 1'b1; bus.cpu_addr = 12'h201;
        #1;
        n_checks++; if (bus.cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_gnt: got %b want 1", bus.cpu_gnt); end
        tick();
        reset = 1'b1;
        #1;
        n_checks++; if ({bus.mem_en, bus.mem_write} !== 2'b00) begin n_fail++; $display("FAIL rmid_mem_en: got %b want 00", {bus.mem_en, bus.mem_write}); end
        n_checks++; if (bus.cpu_gnt !== 1'b0) begin n_fail++; $display("FAIL rmid_gnt_in_reset: got %b want 0", bus.cpu_gnt); end
        tick();
        n_checks++; if (bus.cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_no_rvalid: got %b want 0", bus.cpu_rvalid); end
        reset = 1'b0;
        bus.ld_req = 1'b1; bus.ld_addr = 12'h320; bus.ld_wdata = 8'h11;
        #1;
        n_checks++; if ({bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt} !== 3'b100) begin n_fail++; $display("FAIL rmid_idle_after: got %b want 100", {bus.ld_gnt, bus.cpu_gnt, bus.drw_gnt}); end
        tick();
        drive_idle();
        n_checks++; if ({bus.mem_write, bus.mem_addr} !== {1'b1, 12'h320}) begin n_fail++; $display("FAIL rmid_first_access: got %b/%h want 1/320", bus.mem_write, bus.mem_addr); end
        n_checks++; if (bus.cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_no_late_rvalid: got %b want 0", bus.cpu_rvalid); end
        tick(); tick();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_cpu_read();
        test_ld_priority();
        test_cpu_lock();
        test_starvation();
        test_draw_burst();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
